// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the RAM port initiator
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [3:0] WR_ALL  = 4'b1111;
  localparam logic [3:0] WR_NONE = 4'b0000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_LD_DATA = 3'd2,
    ST_MERGE   = 3'd3,
    ST_WR      = 3'd4,
    ST_RESP    = 3'd5
  } state_e;

  // Only half and word accesses carry an alignment constraint.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic m;
    m = 1'b0;
    if (size == SZ_HALF) m = lo[0];
    else if (size == SZ_WORD) m = |lo;
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian lane extract/extend for loads and lane merge for stores
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] ram_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = ram_word[{addr_lo, 3'b000} +: 8];
    half_sel  = ram_word[{addr_lo[1], 4'b0000} +: 16];
    load_data = ram_word;
    merged    = store_data;
    case (size)
      SZ_BYTE: begin
        load_data = is_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        merged    = ram_word;
        merged[{addr_lo, 3'b000} +: 8] = store_data[7:0];
      end
      SZ_HALF: begin
        load_data = is_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
        merged    = ram_word;
        merged[{addr_lo[1], 4'b0000} +: 16] = store_data[15:0];
      end
      default: begin
        load_data = ram_word;
        merged    = store_data;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - one-request-at-a-time load/store initiator for a full-word-write RAM
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 32,
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_isRead,
  output logic [3:0]        ram_isWrite,
  output logic [DATA_W-1:0] ram_writeData,
  input  logic [DATA_W-1:0] ram_data
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic                write_q, write_d;
  logic                uns_q, uns_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   wbuf_q, wbuf_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                xfer;
  logic                misal;
  logic                illegal;
  logic [ADDR_W-1:0]   addr_in;
  logic [DATA_W-1:0]   load_data;
  logic [DATA_W-1:0]   merged;

  mem_lane_align u_align (
    .size        (size_q),
    .addr_lo     (addr_q[1:0]),
    .is_unsigned (uns_q),
    .ram_word    (ram_data),
    .store_data  (wbuf_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    uns_d   = uns_q;
    err_d   = err_q;
    wbuf_d  = wbuf_q;
    rdata_d = rdata_q;

    xfer    = req_valid && (state_q == ST_IDLE);
    misal   = misaligned(req_size, req_addr[1:0]);
    illegal = (req_size == SZ_RSVD) || (ERR_ON_MISALIGN && misal);
    addr_in = req_addr;
    if (!ERR_ON_MISALIGN && misal)
      addr_in[1:0] = (req_size == SZ_WORD) ? 2'b00 : {req_addr[1], 1'b0};

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          addr_d  = addr_in;
          size_d  = req_size;
          write_d = req_write;
          uns_d   = req_unsigned;
          wbuf_d  = req_wdata;
          err_d   = illegal;
          // Full-word stores skip the read; narrower stores need the old word first.
          if (illegal) state_d = ST_RESP;
          else if (req_write && req_size == SZ_WORD) state_d = ST_WR;
          else state_d = ST_RD;
        end
      end
      ST_RD:      state_d = write_q ? ST_MERGE : ST_LD_DATA;
      ST_LD_DATA: begin
        rdata_d = load_data;
        state_d = ST_RESP;
      end
      ST_MERGE: begin
        wbuf_d  = merged;
        state_d = ST_WR;
      end
      ST_WR:      state_d = ST_RESP;
      ST_RESP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      wbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      wbuf_q  <= wbuf_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign req_ready     = (state_q == ST_IDLE);
  assign resp_valid    = (state_q == ST_RESP);
  assign ram_isRead    = (state_q == ST_RD);
  assign ram_isWrite   = (state_q == ST_WR) ? WR_ALL : WR_NONE;
  assign ram_address   = addr_q;
  assign ram_writeData = wbuf_q;
  assign resp_rdata    = rdata_q;
  assign resp_error    = err_q;

endmodule
